bayes_log_engine: RTL

Parametrised, streaming log-domain Bayesian inference engine: the next generation of the fixed 4×4 likelihood array, with per-class priors, feature-serial accumulation, saturation and argmax. It holds a writable table of log2-likelihood codes per (class, feature, value), accumulates one observation vector at a time into NCLASS saturating scores over a valid/ready stream, and returns the winning class on a result handshake. It sits between the observation source and the readout/sequencer logic of the Bayesian machine.

---
 rtl/bayes_log_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bayes_log_engine.sv
// Streaming log-domain Bayesian inference engine: writable log2-likelihood
// table and priors, feature-serial saturating accumulation, serial argmax.
module bayes_log_engine #(
  parameter int NCLASS = 4,
  parameter int NFEAT  = 4,
  parameter int NWORD  = 3,
  parameter int LW     = 8,
  parameter int AW     = 12,
  localparam int CW    = (NCLASS > 1) ? $clog2(NCLASS) : 1,
  localparam int FW    = (NFEAT > 1) ? $clog2(NFEAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic                   cfg_prior,
  input  logic [CW-1:0]          cfg_class,
  input  logic [FW-1:0]          cfg_feat,
  input  logic [NWORD-1:0]       cfg_val,
  input  logic [LW-1:0]          cfg_data,
  output logic                   cfg_busy,
  input  logic                   obs_valid,
  output logic                   obs_ready,
  input  logic [NFEAT*NWORD-1:0] obs_val,
  input  logic                   obs_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          res_class,
  output logic [AW-1:0]          res_score
);

  localparam int NV = 1 << NWORD;

  typedef enum logic [1:0] {S_WAIT, S_ADD, S_ARGMAX, S_OUT} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload hold until that edge, and ready never
  // depends combinationally on the partner's valid.
  state_t                 state;
  logic                   fresh;
  logic                   last_q;
  logic [FW-1:0]          feat;
  logic [CW-1:0]          cls;
  logic [NFEAT*NWORD-1:0] obs_q;
  logic [NWORD-1:0]       cur_v;
  logic [NCLASS*AW-1:0]   acc_flat;
  logic [AW-1:0]          cur_acc;

  logic [LW-1:0] tbl   [NCLASS][NFEAT][NV];
  logic [LW-1:0] prior [NCLASS];

  assign cfg_busy  = (state != S_WAIT);
  assign obs_ready = (state == S_WAIT) && !rst;

  // Storage is deliberately not reset so a mid-run reset keeps the model.
  always_ff @(posedge clk) begin
    if (!rst && cfg_we && state == S_WAIT) begin
      if (cfg_prior) prior[cfg_class] <= cfg_data;
      else           tbl[cfg_class][cfg_feat][cfg_val] <= cfg_data;
    end
  end

  always_comb begin
    cur_v = '0;
    for (int f = 0; f < NFEAT; f++)
      if (feat == FW'(f)) cur_v = obs_q[f*NWORD +: NWORD];
  end

  always_comb begin
    cur_acc = '0;
    for (int k = 0; k < NCLASS; k++)
      if (cls == CW'(k)) cur_acc = acc_flat[k*AW +: AW];
  end

  for (genvar c = 0; c < NCLASS; c++) begin : g_cls
    logic [AW-1:0] acc;
    logic [AW-1:0] base;
    logic [AW:0]   sum;

    // The first feature of an inference starts from the prior, later ones
    // from the running score; the carry-out bit drives the clamp.
    always_comb begin
      base = fresh ? AW'(prior[c]) : acc;
      sum  = {1'b0, base} + (AW+1)'(tbl[c][feat][cur_v]);
    end

    always_ff @(posedge clk) begin
      if (rst)                 acc <= '0;
      else if (state == S_ADD) acc <= sum[AW] ? '1 : sum[AW-1:0];
    end

    assign acc_flat[c*AW +: AW] = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      fresh     <= 1'b1;
      last_q    <= 1'b0;
      feat      <= '0;
      cls       <= '0;
      obs_q     <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_score <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (obs_valid) begin
            obs_q  <= obs_val;
            last_q <= obs_last;
            feat   <= '0;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          fresh <= 1'b0;
          if (feat == FW'(NFEAT - 1)) begin
            cls   <= '0;
            state <= last_q ? S_ARGMAX : S_WAIT;
          end else begin
            feat <= feat + 1'b1;
          end
        end
        S_ARGMAX: begin
          // Strict greater-than: on a tie the lower class index keeps the win.
          if (cls == '0 || cur_acc > res_score) begin
            res_class <= cls;
            res_score <= cur_acc;
          end
          if (cls == CW'(NCLASS - 1)) begin
            res_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            cls <= cls + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            fresh     <= 1'b1;
            state     <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
